// File: rtl/ehr_pipeline_fifo.sv
// ehr_pipeline_fifo: pipeline FIFO placed after the EHR register stage.
// Ordering within a cycle is first < deq < enq < clear, so a full FIFO can
// still accept an entry in a cycle that also dequeues, giving full
// throughput between adjacent stages.
module ehr_pipeline_fifo #(
  parameter int                 DATA_SZ   = 32,
  parameter int                 DEPTH     = 4,
  parameter logic [DATA_SZ-1:0] RESET_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN_enq,
  input  logic [DATA_SZ-1:0]         enq_data,
  output logic                       RDY_enq,
  input  logic                       EN_deq,
  output logic                       RDY_deq,
  output logic [DATA_SZ-1:0]         first,
  input  logic                       EN_clear,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_SZ-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   hd;
  logic [PTR_W-1:0]   tl;
  logic [CNT_W-1:0]   cnt;

  logic do_enq;
  logic do_deq;

  // Status outputs and qualified strobes; the dequeue strobe may free a slot
  // for the enqueue in the same cycle, the enqueue never affects readiness.
  always_comb begin
    RDY_deq = (cnt != '0);
    RDY_enq = (cnt != FULL_CNT) || (EN_deq && RDY_deq);
    first   = mem[hd];
    count   = cnt;
    do_deq  = EN_deq && RDY_deq;
    do_enq  = EN_enq && RDY_enq;
  end

  // Storage: reset to RESET_VAL, written at the tail on an honoured enqueue
  // unless a clear in the same cycle discards it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (do_enq && !EN_clear) begin
      mem[tl] <= enq_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power
  // of two, and clear overrides any dequeue or enqueue in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
    end else if (EN_clear) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
    end else begin
      if (do_deq) begin
        hd <= hd + PTR_W'(1);
      end
      if (do_enq) begin
        tl <= tl + PTR_W'(1);
      end
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ehr_pipeline_fifo.sv
// tb_ehr_pipeline_fifo: directed and randomized checks of ehr_pipeline_fifo
// against a queue-based reference model of the FIFO contents.
module tb_ehr_pipeline_fifo;

  localparam int DATA_SZ = 32;
  localparam int DEPTH   = 4;
  localparam logic [DATA_SZ-1:0] RESET_VAL = '0;

  logic                 CLK;
  logic                 RST;
  logic                 EN_enq;
  logic [DATA_SZ-1:0]   enq_data;
  logic                 RDY_enq;
  logic                 EN_deq;
  logic                 RDY_deq;
  logic [DATA_SZ-1:0]   first;
  logic                 EN_clear;
  logic [$clog2(DEPTH):0] count;

  int testsRun;
  int testsFailed;

  logic [DATA_SZ-1:0] modelQ [$];

  ehr_pipeline_fifo #(
    .DATA_SZ  (DATA_SZ),
    .DEPTH    (DEPTH),
    .RESET_VAL(RESET_VAL)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN_enq  (EN_enq),
    .enq_data(enq_data),
    .RDY_enq (RDY_enq),
    .EN_deq  (EN_deq),
    .RDY_deq (RDY_deq),
    .first   (first),
    .EN_clear(EN_clear),
    .count   (count)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of strobes after the falling edge, checks the
  // combinational view against the model, then advances the model as the
  // next rising edge will: dequeue first, then enqueue, then clear.
  task automatic applyStimulus(input string tag, input logic enq,
                               input logic [DATA_SZ-1:0] data,
                               input logic deq, input logic clr);
    int   sz;
    logic expRdyDeq;
    logic expRdyEnq;
    @(negedge CLK);
    EN_enq   = enq;
    enq_data = data;
    EN_deq   = deq;
    EN_clear = clr;
    #1;
    sz        = modelQ.size();
    expRdyDeq = (sz != 0);
    expRdyEnq = (sz < DEPTH) || (deq && sz != 0);
    checkOutput({tag, ".rdy_deq"}, 32'(RDY_deq), 32'(expRdyDeq));
    checkOutput({tag, ".rdy_enq"}, 32'(RDY_enq), 32'(expRdyEnq));
    checkOutput({tag, ".count"}, 32'(count), 32'(sz));
    if (sz != 0) begin
      checkOutput({tag, ".first"}, first, modelQ[0]);
    end
    if (clr) begin
      modelQ.delete();
    end else begin
      if (deq && expRdyDeq) void'(modelQ.pop_front());
      if (enq && expRdyEnq) modelQ.push_back(data);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    RST      = 1'b1;
    EN_enq   = 1'b0;
    EN_deq   = 1'b0;
    EN_clear = 1'b0;
    enq_data = '0;

    // Power-on reset view
    #1;
    checkOutput("por.count", 32'(count), 32'd0);
    checkOutput("por.rdy_deq", 32'(RDY_deq), 32'd0);
    checkOutput("por.rdy_enq", 32'(RDY_enq), 32'd1);
    checkOutput("por.first", first, RESET_VAL);
    @(negedge CLK);
    RST = 1'b0;

    // Fill and drain
    applyStimulus("fill", 1'b1, 32'hA, 1'b0, 1'b0);
    applyStimulus("fill", 1'b1, 32'hB, 1'b0, 1'b0);
    applyStimulus("fill", 1'b1, 32'hC, 1'b0, 1'b0);
    applyStimulus("fill", 1'b1, 32'hD, 1'b0, 1'b0);
    // Full: enqueue without dequeue must be ignored
    applyStimulus("fullEnq", 1'b1, 32'h99, 1'b0, 1'b0);
    // Full with simultaneous dequeue and enqueue
    applyStimulus("fullBoth", 1'b1, 32'hE, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("drain", 1'b0, 32'h0, 1'b1, 1'b0);
    // Dequeue on empty must be ignored
    applyStimulus("emptyDeq", 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus("emptyDeq", 1'b0, 32'h0, 1'b1, 1'b0);

    // Clear priority at count=2
    applyStimulus("clrPrep", 1'b1, 32'h21, 1'b0, 1'b0);
    applyStimulus("clrPrep", 1'b1, 32'h22, 1'b0, 1'b0);
    applyStimulus("clr", 1'b1, 32'h55, 1'b1, 1'b1);
    applyStimulus("postClr", 1'b1, 32'h66, 1'b0, 1'b0);
    applyStimulus("postClr", 1'b0, 32'h0, 1'b1, 1'b0);

    // Wrap-around: one priming enqueue, then ten cycles of enq+deq
    applyStimulus("wrapPrime", 1'b1, 32'd1, 1'b0, 1'b0);
    for (int i = 2; i <= 11; i++) applyStimulus("wrap", 1'b1, 32'(i), 1'b1, 1'b0);
    applyStimulus("wrapEnd", 1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with three entries
    applyStimulus("rstPrep", 1'b1, 32'h31, 1'b0, 1'b0);
    applyStimulus("rstPrep", 1'b1, 32'h32, 1'b0, 1'b0);
    applyStimulus("rstPrep", 1'b1, 32'h33, 1'b0, 1'b0);
    applyStimulus("rstPrep", 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge CLK);
    EN_enq = 1'b0;
    EN_deq = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    checkOutput("rstAsync.count", 32'(count), 32'd0);
    checkOutput("rstAsync.rdy_deq", 32'(RDY_deq), 32'd0);
    checkOutput("rstAsync.rdy_enq", 32'(RDY_enq), 32'd1);
    checkOutput("rstAsync.first", first, RESET_VAL);
    EN_enq   = 1'b1;
    enq_data = 32'h77;
    EN_deq   = 1'b1;
    @(negedge CLK);
    #1;
    checkOutput("rstHold.count", 32'(count), 32'd0);
    checkOutput("rstHold.first", first, RESET_VAL);
    RST    = 1'b0;
    EN_enq = 1'b0;
    EN_deq = 1'b0;
    modelQ.delete();
    applyStimulus("afterRst", 1'b1, 32'h11, 1'b0, 1'b0);
    applyStimulus("afterRst", 1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(99) < 60), $urandom,
                    ($urandom_range(99) < 50), ($urandom_range(99) < 4));
    end
    applyStimulus("final", 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
